atetris_hvgen: RTL and testbench

ATETRIS_HVGEN -- requirements
Module: atetris_hvgen

---
 rtl/atetris_pkg.sv | 19 +
 rtl/atetris_synwin.sv | 14 +
 rtl/atetris_hvgen.sv | 124 ++++++++++++
 tb/tb_atetris_hvgen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/atetris_pkg.sv
// atetris_pkg -- shared video timing constants and helpers for the Atari Tetris hv generator (rev 1.0)
`default_nettype none
package atetris_pkg;
  localparam int HTOTAL_DEF  = 456;
  localparam int HVIS_DEF    = 336;
  localparam int VTOTAL_DEF  = 262;
  localparam int VVIS_DEF    = 240;

  localparam int HSYNC_WIDTH = 32;
  localparam int VSYNC_WIDTH = 3;
  localparam int HSYNC_BASE  = 32;
  localparam int VSYNC_BASE  = 4;

  // Sign-extend a 5-bit two's-complement offset into the 10-bit window arithmetic.
  function automatic logic [9:0] sext5(input logic [4:0] v);
    return {{5{v[4]}}, v};
  endfunction
endpackage
`default_nettype wire

// File: rtl/atetris_synwin.sv
// atetris_synwin -- counter-compare window: active while start <= pos < start+width (rev 1.0)
`default_nettype none
module atetris_synwin (
  input  logic [9:0] start,
  input  logic [9:0] width,
  input  logic [9:0] pos,
  output logic       active
);
  logic [9:0] stop;

  assign stop   = start + width;
  assign active = (pos >= start) && (pos < stop);
endmodule
`default_nettype wire

// File: rtl/atetris_hvgen.sv
// atetris_hvgen -- Atari Tetris raster timing generator, rev 1.0.
// Define ATETRIS_HVGEN_SHIFT_EN to let HOFS/VOFS shift the sync windows (latched at frame wrap).
`default_nettype none
module atetris_hvgen
  import atetris_pkg::*;
#(
  parameter int HTOTAL = HTOTAL_DEF,
  parameter int HVIS   = HVIS_DEF,
  parameter int VTOTAL = VTOTAL_DEF,
  parameter int VVIS   = VVIS_DEF
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic [3:0] HOFS,
  input  logic [2:0] VOFS,
  output logic       PCE,
  output logic [8:0] HPOS,
  output logic [8:0] VPOS,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       LSTART,
  output logic       FIELD
);
  localparam logic [8:0] H_LAST = 9'(HTOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(VTOTAL - 1);
  localparam logic [8:0] H_VIS  = 9'(HVIS);
  localparam logic [8:0] V_VIS  = 9'(VVIS);
  localparam logic [9:0] H_BASE = 10'(HVIS + HSYNC_BASE);
  localparam logic [9:0] V_BASE = 10'(VVIS + VSYNC_BASE);
  localparam logic [9:0] H_WID  = 10'(HSYNC_WIDTH);
  localparam logic [9:0] V_WID  = 10'(VSYNC_WIDTH);

  logic       phase;
  logic       h_wrap;
  logic       v_wrap;
  logic [8:0] hpos_nx;
  logic [8:0] vpos_nx;
  logic [3:0] hofs_lat;
  logic [2:0] vofs_lat;
  logic [9:0] hs_start;
  logic [9:0] vs_start;
  logic       hs_nx;
  logic       vs_nx;

  always_comb begin
    h_wrap  = (HPOS == H_LAST);
    v_wrap  = (VPOS == V_LAST);
    hpos_nx = h_wrap ? 9'd0 : HPOS + 9'd1;
    vpos_nx = VPOS;
    if (h_wrap) begin
      vpos_nx = v_wrap ? 9'd0 : VPOS + 9'd1;
    end
  end

`ifdef ATETRIS_HVGEN_SHIFT_EN
  // Offsets only change at the frame wrap so a frame never shows a torn sync position.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      hofs_lat <= '0;
      vofs_lat <= '0;
    end else if (phase && h_wrap && v_wrap) begin
      hofs_lat <= HOFS;
      vofs_lat <= VOFS;
    end
  end
`else
  logic unused_ofs;
  assign unused_ofs = ^{HOFS, VOFS};
  assign hofs_lat   = '0;
  assign vofs_lat   = '0;
`endif

  // HOFS counts in pixel pairs; VOFS counts in lines.
  assign hs_start = H_BASE + sext5({hofs_lat, 1'b0});
  assign vs_start = V_BASE + sext5({vofs_lat[2], vofs_lat});

  atetris_synwin u_hsync_win (
    .start  (hs_start),
    .width  (H_WID),
    .pos    ({1'b0, hpos_nx}),
    .active (hs_nx)
  );

  atetris_synwin u_vsync_win (
    .start  (vs_start),
    .width  (V_WID),
    .pos    ({1'b0, vpos_nx}),
    .active (vs_nx)
  );

  // Decodes are computed from the next counter values so they land together with the counters.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      phase  <= 1'b0;
      PCE    <= 1'b0;
      HPOS   <= '0;
      VPOS   <= '0;
      FIELD  <= 1'b0;
      HBLANK <= 1'b0;
      VBLANK <= 1'b0;
      HSYNC  <= 1'b0;
      VSYNC  <= 1'b0;
      LSTART <= 1'b1;
    end else begin
      phase <= ~phase;
      PCE   <= phase;
      if (phase) begin
        HPOS   <= hpos_nx;
        VPOS   <= vpos_nx;
        HBLANK <= (hpos_nx >= H_VIS);
        VBLANK <= (vpos_nx >= V_VIS);
        HSYNC  <= hs_nx;
        VSYNC  <= vs_nx;
        LSTART <= h_wrap;
        if (h_wrap && v_wrap) begin
          FIELD <= ~FIELD;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_atetris_hvgen.sv
// tb_atetris_hvgen -- directed self-checking bench for atetris_hvgen (rev 1.0)
`default_nettype none
module tb_atetris_hvgen;
  // Vertical size reduced (18 lines, 8 visible) so several frames fit in a short run.
  localparam int HT = 456;
  localparam int HV = 336;
  localparam int VT = 18;
  localparam int VV = 8;
  localparam int FRAME_MCLK = 2 * HT * VT;

  logic       MCLK = 1'b0;
  logic       RESET;
  logic [3:0] HOFS;
  logic [2:0] VOFS;
  logic       PCE;
  logic [8:0] HPOS;
  logic [8:0] VPOS;
  logic       HBLANK;
  logic       VBLANK;
  logic       HSYNC;
  logic       VSYNC;
  logic       LSTART;
  logic       FIELD;

  int vectors = 0;
  int errs    = 0;
  int seq_err, dec_err, misalign, tog_mid, field_flip, aligned;
  int vb_lo, vb_hi, vs_lo, vs_hi, hs_lo, hs_hi;
  int exp_hs_lo, exp_hs_hi, exp_vs_lo, exp_vs_hi;

  atetris_hvgen #(.HTOTAL(HT), .HVIS(HV), .VTOTAL(VT), .VVIS(VV)) dut (
    .MCLK   (MCLK),
    .RESET  (RESET),
    .HOFS   (HOFS),
    .VOFS   (VOFS),
    .PCE    (PCE),
    .HPOS   (HPOS),
    .VPOS   (VPOS),
    .HBLANK (HBLANK),
    .VBLANK (VBLANK),
    .HSYNC  (HSYNC),
    .VSYNC  (VSYNC),
    .LSTART (LSTART),
    .FIELD  (FIELD)
  );

  always #5 MCLK = ~MCLK;

  task automatic step(input int n);
    repeat (n) @(negedge MCLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Walks one whole frame pixel by pixel; optionally changes the offsets at line chg.
  task automatic scan_frame(input int chg, input logic [3:0] nh, input logic [2:0] nv);
    int n;
    int h;
    int v;
    logic pv;
    logic pf;
    n = 0;
    while (!(PCE === 1'b1 && HPOS === 9'd0 && VPOS === 9'd0) && n < 2 * FRAME_MCLK) begin
      step(1);
      n++;
    end
    aligned  = (n < 2 * FRAME_MCLK) ? 1 : 0;
    seq_err  = 0; dec_err = 0; misalign = 0; tog_mid = 0;
    vb_lo = 999; vb_hi = -1; vs_lo = 999; vs_hi = -1; hs_lo = 999; hs_hi = -1;
    pv = VSYNC;
    pf = FIELD;
    for (int p = 0; p < VT * HT; p++) begin
      h = p % HT;
      v = p / HT;
      if (HPOS !== 9'(h) || VPOS !== 9'(v) || PCE !== 1'b1) seq_err++;
      if (HBLANK !== (h >= HV)) dec_err++;
      if (VBLANK !== (v >= VV)) dec_err++;
      if (LSTART !== (h == 0)) dec_err++;
      if (VBLANK === 1'b1) begin
        if (v < vb_lo) vb_lo = v;
        if (v > vb_hi) vb_hi = v;
      end
      if (VSYNC === 1'b1) begin
        if (v < vs_lo) vs_lo = v;
        if (v > vs_hi) vs_hi = v;
      end
      if (HSYNC === 1'b1) begin
        if (h < hs_lo) hs_lo = h;
        if (h > hs_hi) hs_hi = h;
      end
      if (VSYNC !== pv && h != 0) misalign++;
      if (FIELD !== pf) tog_mid++;
      pv = VSYNC;
      pf = FIELD;
      if (v == chg && h == 0) begin
        HOFS = nh;
        VOFS = nv;
      end
      step(2);
    end
    field_flip = (FIELD !== pf) ? 1 : 0;
  endtask

  initial begin
`ifdef ATETRIS_HVGEN_SHIFT_EN
    exp_hs_lo = 352; exp_hs_hi = 383; exp_vs_lo = VV + 7; exp_vs_hi = VV + 9;
`else
    exp_hs_lo = 368; exp_hs_hi = 399; exp_vs_lo = VV + 4; exp_vs_hi = VV + 6;
`endif
    RESET = 1'b1;
    HOFS  = 4'd0;
    VOFS  = 3'd0;
    step(3);
    chk("rst_hpos", HPOS, 0);
    chk("rst_vpos", VPOS, 0);
    chk("rst_field", FIELD, 0);
    chk("rst_pce", PCE, 0);
    chk("rst_syncs", {HSYNC, VSYNC}, 0);
    chk("rst_blanks", {HBLANK, VBLANK}, 0);
    chk("rst_lstart", LSTART, 1);

    // Release: PCE lands on MCLK 2, 4, 6 ...
    RESET = 1'b0;
    step(1);
    chk("rel1_pce", PCE, 0);
    chk("rel1_lstart", LSTART, 1);
    step(1);
    chk("rel2_pce", PCE, 1);
    chk("rel2_hpos", HPOS, 1);
    chk("rel2_lstart", LSTART, 0);
    for (int i = 3; i <= 6; i++) begin
      step(1);
      chk("rel_pce_pattern", PCE, (i % 2 == 0) ? 1 : 0);
    end
    step(904);
    chk("m910_hpos", HPOS, 455);
    chk("m910_vpos", VPOS, 0);
    chk("m910_hblank", HBLANK, 1);
    step(1);
    chk("m911_hold", {PCE, HPOS}, {1'b0, 9'd455});
    step(1);
    chk("m912_hpos", HPOS, 0);
    chk("m912_vpos", VPOS, 1);
    chk("m912_lstart", LSTART, 1);
    chk("m912_hblank", HBLANK, 0);
    step(1);
    chk("m913_lstart", {PCE, LSTART}, {1'b0, 1'b1});
    step(1);
    chk("m914_lstart", LSTART, 0);

    // Full frame with offsets 0; new offsets applied mid-frame must not move this frame's syncs.
    scan_frame(VV + 1, 4'h8, 3'd3);
    chk("f1_align", aligned, 1);
    chk("f1_sequence", seq_err, 0);
    chk("f1_decodes", dec_err, 0);
    chk("f1_vblank_lo", vb_lo, VV);
    chk("f1_vblank_hi", vb_hi, VT - 1);
    chk("f1_hsync_lo", hs_lo, 368);
    chk("f1_hsync_hi", hs_hi, 399);
    chk("f1_vsync_lo", vs_lo, VV + 4);
    chk("f1_vsync_hi", vs_hi, VV + 6);
    chk("f1_vsync_align", misalign, 0);
    chk("f1_field_mid", tog_mid, 0);
    chk("f1_field_flip", field_flip, 1);

    // Next frame picks up HOFS=-8, VOFS=+3 when the shift feature is built in.
    scan_frame(-1, 4'h8, 3'd3);
    chk("f2_align", aligned, 1);
    chk("f2_sequence", seq_err, 0);
    chk("f2_decodes", dec_err, 0);
    chk("f2_hsync_lo", hs_lo, exp_hs_lo);
    chk("f2_hsync_hi", hs_hi, exp_hs_hi);
    chk("f2_vsync_lo", vs_lo, exp_vs_lo);
    chk("f2_vsync_hi", vs_hi, exp_vs_hi);
    chk("f2_vsync_align", misalign, 0);
    chk("f2_field_flip", field_flip, 1);

    // Mid-frame reset at HPOS=200, VPOS=10.
    step(2 * (10 * HT + 200));
    chk("pre_rst_pos", {VPOS, HPOS}, {9'd10, 9'd200});
    RESET = 1'b1;
    step(1);
    chk("mid_rst_hpos", HPOS, 0);
    chk("mid_rst_vpos", VPOS, 0);
    chk("mid_rst_field", FIELD, 0);
    chk("mid_rst_lstart", LSTART, 1);
    chk("mid_rst_pce", PCE, 0);
    RESET = 1'b0;
    step(1);
    chk("mid_rel1_pce", PCE, 0);
    step(1);
    chk("mid_rel2_pce", PCE, 1);
    // Latched offsets cleared by reset: HPOS 390 is inside the unshifted window only.
    step(778);
    chk("post_rst_hpos", HPOS, 390);
    chk("post_rst_hsync", HSYNC, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
`default_nettype wire
